// File: rtl/fetch_ctrl.sv
// Fetch/redirect controller: arbitrates exception, branch and interrupt redirects,
// squashes the front end for a fixed number of cycles, and handles debug halt and stalls.
module fetch_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_jump_req_i,
   input  logic [2:0]  ex_jump_cause_i,
   input  logic [31:0] ex_jump_from_i,
   input  logic [31:0] ex_jump_to_i,
   input  logic        exc_req_i,
   input  logic [31:0] exc_from_i,
   input  logic [31:0] exc_to_i,
   input  logic        irq_req_i,
   input  logic [31:0] irq_to_i,
   input  logic        ld_use_i,
   input  logic        bus_wait_i,
   input  logic        jtag_halt_i,
   output logic [2:0]  jump_cause_o,
   output logic [31:0] jump_from_addr_o,
   output logic [31:0] jump_to_addr_o,
   output logic [2:0]  hold_flag_o,
   output logic        flush_o,
   output logic        irq_ack_o,
   output logic        halted_o,
   output logic [15:0] mispredict_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] LP_FLUSH_LOAD = 4'(FLUSH_CYCLES);

   localparam logic [2:0] CAUSE_NONE = 3'b000;
   localparam logic [2:0] CAUSE_PNBY = 3'b001;
   localparam logic [2:0] CAUSE_PYBN = 3'b010;
   localparam logic [2:0] CAUSE_NCON = 3'b011;
   localparam logic [2:0] CAUSE_IRQ  = 3'b100;
   localparam logic [2:0] CAUSE_EXC  = 3'b101;

   state_t      r_state, w_state_next;
   logic [3:0]  r_flush_cnt, w_flush_cnt_next;
   logic [2:0]  r_cause, w_cause_next;
   logic [31:0] r_from, w_from_next;
   logic [31:0] r_to, w_to_next;
   logic        r_flush, w_flush_next;
   logic        r_irq_ack, w_irq_ack_next;
   logic [15:0] r_mispredict_cnt;
   logic        w_ex_valid;
   logic        w_irq_ok;
   logic        w_redirect;

   assign w_ex_valid = ex_jump_req_i &&
                       ((ex_jump_cause_i == CAUSE_PNBY) ||
                        (ex_jump_cause_i == CAUSE_PYBN) ||
                        (ex_jump_cause_i == CAUSE_NCON));
   // Interrupts wait for a quiet pipeline; the request is level so nothing is lost.
   assign w_irq_ok   = irq_req_i && !exc_req_i && !w_ex_valid &&
                       !bus_wait_i && !ld_use_i && !jtag_halt_i;
   assign w_redirect = (r_state == ST_RUN) && (exc_req_i || w_ex_valid || w_irq_ok);

   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      w_cause_next     = CAUSE_NONE;
      w_from_next      = 32'd0;
      w_to_next        = 32'd0;
      w_flush_next     = 1'b0;
      w_irq_ack_next   = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (exc_req_i) begin
               w_cause_next = CAUSE_EXC;
               w_from_next  = exc_from_i;
               w_to_next    = exc_to_i;
            end else if (w_ex_valid) begin
               w_cause_next = ex_jump_cause_i;
               w_from_next  = ex_jump_from_i;
               w_to_next    = ex_jump_to_i;
            end else if (w_irq_ok) begin
               w_cause_next   = CAUSE_IRQ;
               w_to_next      = irq_to_i;
               w_irq_ack_next = 1'b1;
            end
            if (w_redirect) begin
               w_state_next     = ST_FLUSH;
               w_flush_cnt_next = LP_FLUSH_LOAD;
               w_flush_next     = 1'b1;
            end else if (jtag_halt_i) begin
               w_state_next = ST_HALT;
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt == 4'd0) begin
               w_state_next = jtag_halt_i ? ST_HALT : ST_RUN;
            end else begin
               w_flush_cnt_next = r_flush_cnt - 4'd1;
               w_flush_next     = 1'b1;
            end
         end
         ST_HALT: begin
            if (!jtag_halt_i) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 4'd0;
         r_cause     <= CAUSE_NONE;
         r_from      <= 32'd0;
         r_to        <= 32'd0;
         r_flush     <= 1'b0;
         r_irq_ack   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_flush_cnt <= w_flush_cnt_next;
         r_cause     <= w_cause_next;
         r_from      <= w_from_next;
         r_to        <= w_to_next;
         r_flush     <= w_flush_next;
         r_irq_ack   <= w_irq_ack_next;
      end
   end

   // Counts the cycles in which a mispredict redirect is presented to the PC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mispredict_cnt <= 16'd0;
      end else if (((r_cause == CAUSE_PNBY) || (r_cause == CAUSE_PYBN)) &&
                   (r_mispredict_cnt != 16'hFFFF)) begin
         r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
      end
   end

   // A redirect being presented always overrides any stall.
   always_comb begin
      hold_flag_o = 3'b000;
      if (r_cause == CAUSE_NONE) begin
         if (r_state == ST_HALT)                          hold_flag_o = 3'b111;
         else if ((r_state == ST_RUN) && bus_wait_i)      hold_flag_o = 3'b111;
         else if ((r_state == ST_RUN) && ld_use_i)        hold_flag_o = 3'b011;
      end
   end

   assign jump_cause_o     = r_cause;
   assign jump_from_addr_o = r_from;
   assign jump_to_addr_o   = r_to;
   assign flush_o          = r_flush;
   assign irq_ack_o        = r_irq_ack;
   assign halted_o         = (r_state == ST_HALT);
   assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-count based model.
module tb_fetch_ctrl;

   localparam int F = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_jump_req_i;
   logic [2:0]  ex_jump_cause_i;
   logic [31:0] ex_jump_from_i, ex_jump_to_i;
   logic        exc_req_i;
   logic [31:0] exc_from_i, exc_to_i;
   logic        irq_req_i;
   logic [31:0] irq_to_i;
   logic        ld_use_i, bus_wait_i, jtag_halt_i;
   logic [2:0]  jump_cause_o;
   logic [31:0] jump_from_addr_o, jump_to_addr_o;
   logic [2:0]  hold_flag_o;
   logic        flush_o, irq_ack_o, halted_o;
   logic [15:0] mispredict_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.FLUSH_CYCLES(F)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_jump_req_i(ex_jump_req_i), .ex_jump_cause_i(ex_jump_cause_i),
      .ex_jump_from_i(ex_jump_from_i), .ex_jump_to_i(ex_jump_to_i),
      .exc_req_i(exc_req_i), .exc_from_i(exc_from_i), .exc_to_i(exc_to_i),
      .irq_req_i(irq_req_i), .irq_to_i(irq_to_i),
      .ld_use_i(ld_use_i), .bus_wait_i(bus_wait_i), .jtag_halt_i(jtag_halt_i),
      .jump_cause_o(jump_cause_o), .jump_from_addr_o(jump_from_addr_o),
      .jump_to_addr_o(jump_to_addr_o), .hold_flag_o(hold_flag_o),
      .flush_o(flush_o), .irq_ack_o(irq_ack_o), .halted_o(halted_o),
      .mispredict_cnt_o(mispredict_cnt_o)
   );

   always #5 clk = ~clk;

   // Model: mode 0 running, 1 squashing, 2 halted; m_left = squash cycles still to come.
   int          m_mode, n_mode, m_left, n_left;
   logic [2:0]  m_cause, n_cause;
   logic [31:0] m_from, n_from, m_to, n_to;
   logic        m_ack, n_ack;
   logic [15:0] m_cnt, n_cnt;
   bit          m_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [2:0] exp_hold;
      exp_hold = 3'b000;
      if (m_cause == 3'b000) begin
         if (m_mode == 2)                      exp_hold = 3'b111;
         else if (m_mode == 0 && bus_wait_i)   exp_hold = 3'b111;
         else if (m_mode == 0 && ld_use_i)     exp_hold = 3'b011;
      end
      chk("cause", 32'(jump_cause_o), 32'(m_cause));
      chk("from", jump_from_addr_o, m_from);
      chk("to", jump_to_addr_o, m_to);
      chk("flush", 32'(flush_o), 32'(m_mode == 1));
      chk("irq_ack", 32'(irq_ack_o), 32'(m_ack));
      chk("halted", 32'(halted_o), 32'(m_mode == 2));
      chk("mis_cnt", 32'(mispredict_cnt_o), 32'(m_cnt));
      chk("hold", 32'(hold_flag_o), 32'(exp_hold));
   endtask

   task automatic model_next();
      bit ex_ok, taken;
      n_cause = 3'b000; n_from = 0; n_to = 0; n_ack = 0;
      n_mode = m_mode; n_left = m_left;
      n_cnt = m_cnt;
      if ((m_cause == 3'd1 || m_cause == 3'd2) && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
      taken = 0;
      ex_ok = ex_jump_req_i && ex_jump_cause_i >= 3'd1 && ex_jump_cause_i <= 3'd3;
      if (m_mode == 0) begin
         if (exc_req_i) begin
            n_cause = 3'd5; n_from = exc_from_i; n_to = exc_to_i; taken = 1;
         end else if (ex_ok) begin
            n_cause = ex_jump_cause_i; n_from = ex_jump_from_i; n_to = ex_jump_to_i; taken = 1;
         end else if (irq_req_i && !bus_wait_i && !ld_use_i && !jtag_halt_i) begin
            n_cause = 3'd4; n_to = irq_to_i; n_ack = 1; taken = 1;
         end else if (jtag_halt_i) begin
            n_mode = 2;
         end
         if (taken) begin
            n_mode = 1; n_left = F + 1;
         end
      end else if (m_mode == 1) begin
         n_left = m_left - 1;
         if (n_left == 0) n_mode = jtag_halt_i ? 2 : 0;
      end else begin
         if (!jtag_halt_i) n_mode = 0;
      end
      if (!rst_n) begin
         n_mode = 0; n_left = 0; n_cause = 0; n_from = 0; n_to = 0; n_ack = 0; n_cnt = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (m_valid) compare_all();
      model_next();
      @(posedge clk);
      #1;
      if (!rst_n) m_valid = 1;
      m_mode = n_mode; m_left = n_left; m_cause = n_cause;
      m_from = n_from; m_to = n_to; m_ack = n_ack; m_cnt = n_cnt;
   endtask

   task automatic clear_inputs();
      ex_jump_req_i = 0; ex_jump_cause_i = 0; ex_jump_from_i = 0; ex_jump_to_i = 0;
      exc_req_i = 0; exc_from_i = 0; exc_to_i = 0;
      irq_req_i = 0; irq_to_i = 0;
      ld_use_i = 0; bus_wait_i = 0; jtag_halt_i = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      clear_inputs();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      chk("rst_cause", 32'(jump_cause_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      chk("rst_halted", 32'(halted_o), 32'd0);
      chk("rst_cnt", 32'(mispredict_cnt_o), 32'd0);
      tick(); tick();

      // Branch mispredict: one output cycle then F more squash cycles.
      ex_jump_req_i = 1; ex_jump_cause_i = 3'b010; ex_jump_from_i = 32'h40; ex_jump_to_i = 32'h100;
      tick();
      clear_inputs();
      chk("br_cause", 32'(jump_cause_o), 32'd2);
      chk("br_to", jump_to_addr_o, 32'h100);
      chk("br_flush11", 32'(flush_o), 32'd1);
      tick(); chk("br_flush12", 32'(flush_o), 32'd1);
      tick(); chk("br_flush13", 32'(flush_o), 32'd1);
      tick(); chk("br_flush14", 32'(flush_o), 32'd0);
      chk("br_cnt", 32'(mispredict_cnt_o), 32'd1);

      // Exception beats branch and interrupt; interrupt taken once squash ends.
      exc_req_i = 1; exc_from_i = 32'h44; exc_to_i = 32'h80;
      ex_jump_req_i = 1; ex_jump_cause_i = 3'b001; ex_jump_to_i = 32'h900;
      irq_req_i = 1; irq_to_i = 32'h200;
      tick();
      exc_req_i = 0; ex_jump_req_i = 0;
      chk("pri_cause", 32'(jump_cause_o), 32'd5);
      chk("pri_to", jump_to_addr_o, 32'h80);
      chk("pri_ack11", 32'(irq_ack_o), 32'd0);
      tick(); chk("pri_ack12", 32'(irq_ack_o), 32'd0);
      tick(); chk("pri_ack13", 32'(irq_ack_o), 32'd0);
      tick(); chk("pri_ack14", 32'(irq_ack_o), 32'd0);
      tick();
      chk("irq_ack", 32'(irq_ack_o), 32'd1);
      chk("irq_cause", 32'(jump_cause_o), 32'd4);
      chk("irq_from", jump_from_addr_o, 32'h0);
      chk("irq_to", jump_to_addr_o, 32'h200);
      clear_inputs();
      tick(); tick(); tick();

      // Branch request during squash is dropped.
      ex_jump_req_i = 1; ex_jump_cause_i = 3'b001; ex_jump_to_i = 32'h300;
      tick();
      ex_jump_cause_i = 3'b010; ex_jump_to_i = 32'h400;
      chk("sq_first", 32'(jump_cause_o), 32'd1);
      tick();
      chk("sq_ignored", 32'(jump_cause_o), 32'd0);
      clear_inputs();
      tick(); tick();
      chk("sq_cnt", 32'(mispredict_cnt_o), 32'd2);

      // Stalls and held interrupt.
      ld_use_i = 1; #1;
      chk("hold_ld", 32'(hold_flag_o), 32'd3);
      tick();
      bus_wait_i = 1; irq_req_i = 1; irq_to_i = 32'h240; #1;
      chk("hold_bus", 32'(hold_flag_o), 32'd7);
      tick(); chk("stall_ack1", 32'(irq_ack_o), 32'd0);
      tick(); chk("stall_ack2", 32'(irq_ack_o), 32'd0);
      ld_use_i = 0; bus_wait_i = 0; #1;
      chk("hold_free", 32'(hold_flag_o), 32'd0);
      tick(); chk("stall_ack3", 32'(irq_ack_o), 32'd1);
      clear_inputs();
      tick(); tick(); tick();

      // Debug halt, release, and reset while halted.
      jtag_halt_i = 1;
      tick(); #1;
      chk("halt_on", 32'(halted_o), 32'd1);
      chk("halt_hold", 32'(hold_flag_o), 32'd7);
      jtag_halt_i = 0;
      tick(); #1;
      chk("halt_off", 32'(halted_o), 32'd0);
      chk("halt_hold0", 32'(hold_flag_o), 32'd0);
      jtag_halt_i = 1;
      tick();
      rst_n = 0; jtag_halt_i = 0;
      tick();
      rst_n = 1;
      chk("hrst_halted", 32'(halted_o), 32'd0);
      chk("hrst_cnt", 32'(mispredict_cnt_o), 32'd0);
      chk("hrst_cause", 32'(jump_cause_o), 32'd0);
      tick();

      // Saturation: preload near the top, then push past it.
      force dut.r_mispredict_cnt = 16'hFFFC;
      #1;
      release dut.r_mispredict_cnt;
      m_cnt = 16'hFFFC;
      for (int k = 0; k < 6; k++) begin
         ex_jump_req_i = 1; ex_jump_cause_i = (k % 2 == 0) ? 3'b001 : 3'b010;
         ex_jump_to_i = 32'h1000 + 32'(k);
         tick();
         clear_inputs();
         for (int j = 0; j < F + 1; j++) tick();
      end
      chk("sat_cnt", 32'(mispredict_cnt_o), 32'hFFFF);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst_n           = ($urandom_range(0, 299) != 0);
         exc_req_i       = ($urandom_range(0, 15) == 0);
         exc_from_i      = $urandom; exc_to_i = $urandom;
         ex_jump_req_i   = ($urandom_range(0, 3) == 0);
         ex_jump_cause_i = 3'($urandom_range(0, 7));
         ex_jump_from_i  = $urandom; ex_jump_to_i = $urandom;
         irq_req_i       = ($urandom_range(0, 3) == 0);
         irq_to_i        = $urandom;
         ld_use_i        = ($urandom_range(0, 4) == 0);
         bus_wait_i      = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) jtag_halt_i = ~jtag_halt_i;
         tick();
      end
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
